// File: rtl/operand_fetch_if.sv
// Register-file port bundle: two combinational read ports and one write port.
// Master is the operand-fetch stage (addresses out, data in); slave is the regfile.
interface operand_fetch_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [AW-1:0] rna;
    logic [AW-1:0] rnb;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic [AW-1:0] wn;
    logic          we;
    logic [DW-1:0] d;

    modport master (
        output rna, rnb, wn, we, d,
        input  qa, qb
    );

    modport slave (
        input  rna, rnb, wn, we, d,
        output qa, qb
    );
endinterface

// File: rtl/operand_fetch.sv
// ID-stage operand fetch: regfile read/write drive, EX/MEM/WB forwarding, load-use stall.
// Operands land in ID/EX one edge after issue; stall is combinational and holds PC/IF-ID one cycle.
module operand_fetch #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [AW-1:0] id_wn,
    input  logic          id_wreg,
    input  logic          id_m2reg,
    input  logic          flush,
    input  logic [DW-1:0] ex_alu,
    input  logic [DW-1:0] mem_alu,
    input  logic [DW-1:0] mem_mo,
    input  logic [DW-1:0] wb_d,
    operand_fetch_if.master rf,
    output logic          stall,
    output logic          e_valid,
    output logic [DW-1:0] ea,
    output logic [DW-1:0] eb,
    output logic [AW-1:0] e_wn,
    output logic          e_wreg,
    output logic          e_m2reg
);

    logic [AW-1:0] mem_wn;
    logic          mem_wreg;
    logic          mem_m2reg;
    logic [AW-1:0] wb_wn;
    logic          wb_wreg;

    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          ex_load;
    logic          issue;

    assign rf.rna = id_rs;
    assign rf.rnb = id_rt;
    assign rf.wn  = wb_wn;
    assign rf.we  = wb_wreg && (wb_wn != '0);
    assign rf.d   = wb_d;

    // Loads in EX have no data yet, so they are skipped here and handled by stall.
    function automatic logic [DW-1:0] resolve(input logic [AW-1:0] s, input logic [DW-1:0] q);
        if (s == '0)
            return '0;
        if (e_wreg && (e_wn == s) && !e_m2reg)
            return ex_alu;
        if (mem_wreg && (mem_wn == s))
            return mem_m2reg ? mem_mo : mem_alu;
        if (wb_wreg && (wb_wn == s))
            return wb_d;
        return q;
    endfunction

    always_comb begin
        opa = resolve(id_rs, rf.qa);
        opb = resolve(id_rt, rf.qb);
    end

    assign ex_load = e_wreg && e_m2reg && (e_wn != '0);
    assign stall   = id_valid && !flush && ex_load &&
                     ((id_use_rs && (id_rs == e_wn)) || (id_use_rt && (id_rt == e_wn)));
    assign issue   = id_valid && !flush && !stall;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            e_valid   <= 1'b0;
            ea        <= '0;
            eb        <= '0;
            e_wn      <= '0;
            e_wreg    <= 1'b0;
            e_m2reg   <= 1'b0;
            mem_wn    <= '0;
            mem_wreg  <= 1'b0;
            mem_m2reg <= 1'b0;
            wb_wn     <= '0;
            wb_wreg   <= 1'b0;
        end else begin
            wb_wn     <= mem_wn;
            wb_wreg   <= mem_wreg;
            mem_wn    <= e_wn;
            mem_wreg  <= e_wreg;
            mem_m2reg <= e_m2reg;
            e_valid   <= issue;
            if (issue) begin
                ea      <= opa;
                eb      <= opb;
                e_wn    <= id_wn;
                e_wreg  <= id_wreg;
                e_m2reg <= id_m2reg;
            end else begin
                e_wn    <= '0;
                e_wreg  <= 1'b0;
                e_m2reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: forwarding, load-use stall, flush, WB bypass and async reset.
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        clrn;
    logic        id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, flush;
    logic [4:0]  id_rs, id_rt, id_wn;
    logic [31:0] ex_alu, mem_alu, mem_mo, wb_d;
    logic        stall, e_valid, e_wreg, e_m2reg;
    logic [31:0] ea, eb;
    logic [4:0]  e_wn;

    int checks = 0;
    int errors = 0;

    operand_fetch_if #(.DW(32), .AW(5)) rf ();

    operand_fetch #(.DW(32), .AW(5)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_wn     (id_wn),
        .id_wreg   (id_wreg),
        .id_m2reg  (id_m2reg),
        .flush     (flush),
        .ex_alu    (ex_alu),
        .mem_alu   (mem_alu),
        .mem_mo    (mem_mo),
        .wb_d      (wb_d),
        .rf        (rf),
        .stall     (stall),
        .e_valid   (e_valid),
        .ea        (ea),
        .eb        (eb),
        .e_wn      (e_wn),
        .e_wreg    (e_wreg),
        .e_m2reg   (e_m2reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                          input logic urt, input logic [4:0] wn, input logic wr, input logic ld);
        id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_wn = wn; id_wreg = wr; id_m2reg = ld;
    endtask

    task automatic bubbles(input int n);
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        clrn = 1'b0; flush = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        ex_alu = '0; mem_alu = '0; mem_mo = '0; wb_d = '0; rf.qa = '0; rf.qb = '0;
        #2;
        chk("rst_e_valid", 32'(e_valid), 32'd0);
        chk("rst_ea", ea, 32'd0);
        chk("rst_we", 32'(rf.we), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk); clrn = 1'b1;
        tick();

        // ALU result forwarded from EX
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        ex_alu = 32'h11; #1;
        chk("ex_fwd_stall", 32'(stall), 32'd0);
        tick();
        chk("ex_fwd_valid", 32'(e_valid), 32'd1);
        chk("ex_fwd_ea", ea, 32'h11);
        chk("ex_fwd_wn", 32'(e_wn), 32'd4);
        bubbles(3);

        // load-use: one stall, one bubble, then mem_mo forward
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        rf.qa = 32'h0; rf.qb = 32'h1234; #1;
        chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_bubble", 32'(e_valid), 32'd0);
        chk("lu_stall_done", 32'(stall), 32'd0);
        mem_mo = 32'hCAFEBABE;
        tick();
        chk("lu_valid", 32'(e_valid), 32'd1);
        chk("lu_ea", ea, 32'hCAFEBABE);
        chk("lu_eb", eb, 32'h1234);
        chk("lu_wn", 32'(e_wn), 32'd6);
        bubbles(3);

        // WB bypass while regfile still holds the old value
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        bubbles(2);
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        wb_d = 32'h77; rf.qa = 32'h0; #1;
        chk("wb_we", 32'(rf.we), 32'd1);
        chk("wb_wn", 32'(rf.wn), 32'd7);
        chk("wb_d", rf.d, 32'h77);
        tick();
        chk("wb_ea", ea, 32'h77);
        bubbles(3);

        // EX beats MEM; r0 always reads zero and never writes
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        tick();
        tick();
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        ex_alu = 32'h1; mem_alu = 32'h2; rf.qb = 32'h99;
        tick();
        chk("prio_ea", ea, 32'h1);
        chk("r0_eb", eb, 32'h0);
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        ex_alu = 32'h55; rf.qa = 32'h99;
        tick();
        chk("r0_ea", ea, 32'h0);
        bubbles(1);
        chk("r0_we", 32'(rf.we), 32'd0);
        bubbles(2);

        // flush overrides load-use; unused rt never stalls
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        flush = 1'b1; #1;
        chk("flush_stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_bubble", 32'(e_valid), 32'd0);
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd4, 1'b0, 5'd9, 1'b1, 1'b0);
        #1;
        chk("unused_rt_stall", 32'(stall), 32'd0);
        tick();
        chk("unused_rt_valid", 32'(e_valid), 32'd1);
        bubbles(3);

        // async reset in the middle of a stall
        rf.qa = 32'hAAAA;
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        chk("pre_rst_ea", ea, 32'hAAAA);
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        clrn = 1'b0; #1;
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_e_valid", 32'(e_valid), 32'd0);
        chk("arst_ea", ea, 32'd0);
        chk("arst_e_wn", 32'(e_wn), 32'd0);
        chk("arst_e_wreg", 32'(e_wreg), 32'd0);
        chk("arst_e_m2reg", 32'(e_m2reg), 32'd0);
        @(negedge clk); clrn = 1'b1;
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        #1;
        chk("post_rst_lw_stall", 32'(stall), 32'd0);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        chk("post_rst_stall", 32'(stall), 32'd1);
        tick();
        chk("post_rst_stall_once", 32'(stall), 32'd0);
        chk("post_rst_bubble", 32'(e_valid), 32'd0);
        mem_mo = 32'h5555;
        tick();
        chk("post_rst_valid", 32'(e_valid), 32'd1);
        chk("post_rst_ea", ea, 32'h5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
